surf_dna_seq: RTL and testbench
===============================

// Module: surf_dna_seq
// PURPOSE
//  Sequencer/arbiter for the DNA_PORTE2 device-DNA primitive. Automatically reads the full
//  96-bit DNA after reset or on request and holds it in a register. Optionally shares the
//  primitive with the bit-bang DNA register path in the ID/control block. Sits beside the
//  ID/control register block in the wishbone clock domain, and drives the primitive's READ/SHIFT pins.
// PARAMETERS
//  DNA_BITS   96  number of DNA bits shifted out (7-bit counter sized by $clog2(DNA_BITS+1))
//  SHIFT_DIV  1   idle cycles between shift pulses (keeps the DNA CLK-rate limit met)
//  AUTOLOAD   1   1 = start a read automatically after reset release; 0 = wait for reload_i
// PORTS
//  wb_clk_i     in   1         wishbone clock; the only clock
//  wb_rst_n_i   in   1         asynchronous, active-low reset
//  reload_i     in   1         single-cycle request to re-read DNA
//  busy_o       out  1         sequencer owns primitive (state != IDLE)
//  valid_o      out  1         dna_o holds a complete read
//  dna_o        out  DNA_BITS  captured DNA, bit i = i-th bit shifted out
//  bb_req_i     in   1         bit-bang requester wants the primitive
//  bb_read_i    in   1         bit-bang READ (honoured only while granted)
//  bb_shift_i   in   1         bit-bang SHIFT (honoured only while granted)
//  bb_gnt_o     out  1         bit-bang path granted
//  dna_read_o   out  1         to DNA_PORTE2 READ
//  dna_shift_o  out  1         to DNA_PORTE2 SHIFT
//  dna_dout_i   in   1         from DNA_PORTE2 DOUT
// BEHAVIOUR
//  Reset (async assert): state=IDLE; busy_o/valid_o/bb_gnt_o/dna_read_o/dna_shift_o=0; dna_o=0; pending=0.
//  FSM, all outputs registered:
//   IDLE   -> LOAD when (pending|reload_i|autoload-first-cycle) && !bb_gnt_o
//   LOAD   1 cycle, dna_read_o=1, valid_o cleared, bit counter=0 -> SETTLE
//   SETTLE 1 cycle, read/shift both 0 -> SHIFT
//   SHIFT  period SHIFT_DIV+1 cycles per bit. On the first cycle of a period: sample
//          dna_dout_i into shadow[cnt] and assert dna_shift_o for that cycle only. Repeat
//          DNA_BITS times; after the last period -> DONE. The final shift is harmless.
//   DONE   1 cycle: dna_o<=shadow; valid_o<=1 on exit -> IDLE
//  dna_o never shows a partial read: it changes only in DONE.
//  Latency: with AUTOLOAD=1, valid_o rises on edge 3+DNA_BITS*(SHIFT_DIV+1) counted from the
//   first edge after reset release. Edge 1 enters LOAD. Defaults give edge 195.
//  reload_i while busy_o: sets pending, and exactly one further read follows; extra requests merge.
//  reload_i while bb_gnt_o: sets pending; LOAD starts the cycle after bb_req_i drops.
//  Arbitration: bb_gnt_o<=1 only from IDLE with bb_req_i && !pending && !reload_i.
//   The sequencer has priority on a same-cycle tie. The grant holds until bb_req_i=0 and
//   drops 1 cycle later.
//  While granted: dna_read_o/dna_shift_o = registered bb_read_i/bb_shift_i (1-cycle latency);
//   otherwise bb_* inputs are ignored.
//  Bit-bang reads do not modify dna_o or valid_o.
//  AUTOLOAD=0: IDLE waits for reload_i; valid_o stays 0 until the first read completes.
// CONFIGURATION
//  SURF_DNA_BITBANG_EN defined: bit-bang arbitration as above.
//  Not defined: bb_gnt_o tied 0, bb_req_i/bb_read_i/bb_shift_i ignored; pending is set only
//   by reload_i during busy.
// STRUCTURE
//  surf_dna_pkg: dna_state_t enum {IDLE,LOAD,SETTLE,SHIFT,DONE}, DNA_BITS_DEFAULT=96.
//  Single module, no sub-module. The shift-period timer and bit counter live inline.
//  The DNA_PORTE2 instance stays outside; the block only drives its pins.
// TESTING
//  Behavioural DNA_PORTE2 model, pattern 96'hA5C3_0F1E_2D3C_4B5A_6978_8796:
//  1 reset release, AUTOLOAD=1, SHIFT_DIV=1 -> dna_read_o pulse on edge 1; exactly 96 one-cycle
//    dna_shift_o pulses 2 cycles apart; valid_o on edge 195; dna_o == pattern.
//  2 reload_i pulsed twice mid-SHIFT -> exactly one extra LOAD after DONE; valid_o low for that
//    read; dna_o unchanged until its DONE.
//  3 bb_req_i and reload_i in the same IDLE cycle -> LOAD wins, bb_gnt_o=0. After DONE,
//    bb_gnt_o=1 next cycle; bb_shift_i echoed on dna_shift_o 1 cycle later.
//  4 reload_i while granted -> no LOAD until bb_req_i=0; LOAD starts the next cycle;
//    bb_shift_i is no longer echoed.
//  5 wb_rst_n_i asserted at bit 40 of SHIFT -> all outputs 0 immediately. After release,
//    a fresh full read completes in 195 edges with correct dna_o.
//  6 SURF_DNA_BITBANG_EN undefined, bb_req_i=1 held -> bb_gnt_o stays 0; autoload completes normally.

Source files
------------

// File: rtl/surf_dna_pkg.sv
// Shared types and constants for the DNA_PORTE2 read sequencer.
//   dna_state_t      : sequencer FSM states
//   DNA_BITS_DEFAULT : number of DNA bits the primitive shifts out
package surf_dna_pkg;

   localparam int DNA_BITS_DEFAULT = 96;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SETTLE = 3'd2,
      SHIFT  = 3'd3,
      DONE   = 3'd4
   } dna_state_t;

endpackage

// File: rtl/surf_dna_seq.sv
// Sequencer/arbiter for the DNA_PORTE2 device-DNA primitive.
// Reads the full DNA after reset (AUTOLOAD) or on reload_i and holds it in dna_o.
// Optionally shares the primitive with the bit-bang DNA register path.
//
// Build option: define SURF_DNA_BITBANG_EN to enable bit-bang arbitration.
// Without it bb_gnt_o stays 0 and the bb_* inputs are ignored.
//
// Ports (clock wb_clk_i, async active-low reset wb_rst_n_i):
//   reload_i     in   request a fresh DNA read (single cycle)
//   busy_o       out  sequencer owns the primitive
//   valid_o      out  dna_o holds a complete read
//   dna_o        out  captured DNA, bit i = i-th bit shifted out
//   bb_req_i     in   bit-bang requester wants the primitive
//   bb_read_i    in   bit-bang READ, forwarded while granted
//   bb_shift_i   in   bit-bang SHIFT, forwarded while granted
//   bb_gnt_o     out  bit-bang path granted
//   dna_read_o   out  DNA_PORTE2 READ
//   dna_shift_o  out  DNA_PORTE2 SHIFT
//   dna_dout_i   in   DNA_PORTE2 DOUT
//
// state  | meaning
// IDLE   | primitive free; bit-bang may hold it
// LOAD   | READ pulse, parallel-load DNA into the primitive
// SETTLE | one quiet cycle before shifting
// SHIFT  | sample DOUT then pulse SHIFT, once per SHIFT_DIV+1 cycles
// DONE   | publish the shadow register to dna_o
module surf_dna_seq
   import surf_dna_pkg::*;
#(
   parameter int DNA_BITS  = DNA_BITS_DEFAULT,
   parameter int SHIFT_DIV = 1,
   parameter bit AUTOLOAD  = 1'b1
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_n_i,
   input  logic                reload_i,
   output logic                busy_o,
   output logic                valid_o,
   output logic [DNA_BITS-1:0] dna_o,
   input  logic                bb_req_i,
   input  logic                bb_read_i,
   input  logic                bb_shift_i,
   output logic                bb_gnt_o,
   output logic                dna_read_o,
   output logic                dna_shift_o,
   input  logic                dna_dout_i
);

   localparam int CNT_W = $clog2(DNA_BITS + 1);
   localparam int DIV_W = (SHIFT_DIV < 1) ? 1 : $clog2(SHIFT_DIV + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DNA_BITS - 1);
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SHIFT_DIV);

   dna_state_t          state_q, state_d;
   logic [CNT_W-1:0]    bit_q, bit_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [DNA_BITS-1:0] shadow_q, shadow_d;
   logic                start_q;
   logic                pending_q, pending_d;
   logic                gnt_d, read_d, shift_d;
   logic                seq_req;
   logic                bb_req, bb_read, bb_shift;

`ifdef SURF_DNA_BITBANG_EN
   assign bb_req   = bb_req_i;
   assign bb_read  = bb_read_i;
   assign bb_shift = bb_shift_i;
`else
   logic bb_unused;
   assign bb_unused = ^{bb_req_i, bb_read_i, bb_shift_i};
   assign bb_req    = 1'b0;
   assign bb_read   = 1'b0;
   assign bb_shift  = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      bit_d     = bit_q;
      div_d     = div_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      gnt_d     = 1'b0;
      shift_d   = 1'b0;
      seq_req   = pending_q | reload_i | start_q;

      // A request that arrives while the primitive is taken is remembered;
      // several of them collapse into one follow-up read.
      if (reload_i && state_q != IDLE) begin
         pending_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (bb_gnt_o) begin
               gnt_d = bb_req;
               if (reload_i) begin
                  pending_d = 1'b1;
               end
            end else if (seq_req) begin
               state_d   = LOAD;
               pending_d = 1'b0;
            end else begin
               gnt_d = bb_req;
            end
         end
         LOAD: begin
            bit_d   = '0;
            state_d = SETTLE;
         end
         SETTLE: begin
            state_d = SHIFT;
            div_d   = DIV_LOAD;
            shift_d = 1'b1;
         end
         SHIFT: begin
            // DOUT is sampled on the same edge the SHIFT pulse advances the
            // primitive, so the value captured is the bit before the shift.
            if (div_q == DIV_LOAD) begin
               shadow_d[bit_q] = dna_dout_i;
            end
            if (div_q == '0) begin
               if (bit_q == LAST_BIT) begin
                  state_d = DONE;
               end else begin
                  bit_d   = bit_q + CNT_W'(1);
                  div_d   = DIV_LOAD;
                  shift_d = 1'b1;
               end
            end else begin
               div_d = div_q - DIV_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      read_d  = (state_d == LOAD) | (gnt_d & bb_read);
      shift_d = shift_d | (gnt_d & bb_shift);
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q     <= IDLE;
         bit_q       <= '0;
         div_q       <= '0;
         shadow_q    <= '0;
         start_q     <= AUTOLOAD;
         pending_q   <= 1'b0;
         busy_o      <= 1'b0;
         valid_o     <= 1'b0;
         dna_o       <= '0;
         bb_gnt_o    <= 1'b0;
         dna_read_o  <= 1'b0;
         dna_shift_o <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_q       <= bit_d;
         div_q       <= div_d;
         shadow_q    <= shadow_d;
         start_q     <= 1'b0;
         pending_q   <= pending_d;
         busy_o      <= (state_d != IDLE);
         bb_gnt_o    <= gnt_d;
         dna_read_o  <= read_d;
         dna_shift_o <= shift_d;
         if (state_d == LOAD) begin
            valid_o <= 1'b0;
         end else if (state_d == DONE) begin
            valid_o <= 1'b1;
         end
         // shadow_d includes the final bit when SHIFT_DIV is 0
         if (state_d == DONE) begin
            dna_o <= shadow_d;
         end
      end
   end

endmodule

// File: tb/tb_surf_dna_seq.sv
// Bench for surf_dna_seq with a behavioural DNA_PORTE2 model.
// Completed reads are checked by a scoreboard: the expected DNA is queued when
// a read is launched and popped when valid_o rises. Autoload timing uses a
// vector table; the arbitration corners are hand-written sequences.
module tb_surf_dna_seq;
   import surf_dna_pkg::*;

   localparam int NB = 96;
   localparam logic [NB-1:0] PAT = 96'hA5C3_0F1E_2D3C_4B5A_6978_8796;
   localparam logic [NB-1:0] P2  = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
   localparam logic [NB-1:0] P3  = 96'hDEAD_BEEF_0BAD_F00D_1234_5678;
   localparam logic [NB-1:0] P4  = 96'h5555_AAAA_3333_CCCC_0F0F_F0F0;
   localparam int W_VALID = 0;
   localparam int W_READ  = 1;
   localparam int NV      = 11;

   typedef struct {
      int   e;
      logic rd;
      logic sh;
      logic busy;
      logic valid;
      logic gnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic reload = 1'b0, bb_req = 1'b0, bb_read = 1'b0, bb_shift = 1'b0;
   logic busy, valid, gnt, rd, sh, dout;
   logic [NB-1:0] dna;
   logic [NB-1:0] model_pat = PAT;
   logic [NB-1:0] model_sr = '0;

   int total = 0, bad = 0;
   int load_cnt = 0, shift_cnt = 0, cyc = 0, last_shift_cyc = -1;
   logic valid_prev = 1'b0, rd_prev = 1'b0;
   logic [NB-1:0] exp_q[$];
   vec_t tbl[NV];

   always #5 clk = ~clk;

   surf_dna_seq dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .reload_i   (reload),
      .busy_o     (busy),
      .valid_o    (valid),
      .dna_o      (dna),
      .bb_req_i   (bb_req),
      .bb_read_i  (bb_read),
      .bb_shift_i (bb_shift),
      .bb_gnt_o   (gnt),
      .dna_read_o (rd),
      .dna_shift_o(sh),
      .dna_dout_i (dout)
   );

   // DNA_PORTE2: READ loads the DNA, SHIFT moves the next bit onto DOUT
   assign dout = model_sr[0];
   always @(posedge clk) begin
      if (rd) model_sr <= model_pat;
      else if (sh) model_sr <= model_sr >> 1;
   end

   task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: load/shift accounting, shift spacing, scoreboard on valid rise
   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (rd && !rd_prev && !gnt) begin
            load_cnt++;
            last_shift_cyc = -1;
         end
         if (sh && !gnt) begin
            shift_cnt++;
            if (last_shift_cyc >= 0) chk("shift_gap", NB'(cyc - last_shift_cyc), NB'(2));
            last_shift_cyc = cyc;
         end
         if (valid && !valid_prev) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_unexpected: got dna %h expected no completion", dna);
            end else begin
               chk("sb_dna", dna, exp_q.pop_front());
            end
         end
      end
      valid_prev = valid;
      rd_prev    = rd;
   end

   task automatic adv();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_for(input int which, input int limit, input string name);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < limit; i++) begin
         adv();
         hit = (which == W_VALID) ? (valid === 1'b1) : (rd === 1'b1);
         if (hit) break;
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL %s: no event, got timeout after %0d cycles expected event", name, limit);
      end
   endtask

   task automatic release_reset();
      exp_q.delete();
      model_pat = PAT;
      rst_n = 1'b1;
      exp_q.push_back(PAT);
   endtask

   // edges counted from the first posedge after reset release
   task automatic run_autoload(input string tag);
      int k;
      int s0;
      int l0;
      k  = 0;
      s0 = shift_cnt;
      l0 = load_cnt;
      for (int e = 1; e <= 197; e++) begin
         adv();
         if (e == 194) chk({tag, "_dna_hidden"}, dna, '0);
         if (k < NV && tbl[k].e == e) begin
            chk($sformatf("%s_e%0d_rd", tag, e), NB'(rd), NB'(tbl[k].rd));
            chk($sformatf("%s_e%0d_sh", tag, e), NB'(sh), NB'(tbl[k].sh));
            chk($sformatf("%s_e%0d_busy", tag, e), NB'(busy), NB'(tbl[k].busy));
            chk($sformatf("%s_e%0d_valid", tag, e), NB'(valid), NB'(tbl[k].valid));
            chk($sformatf("%s_e%0d_gnt", tag, e), NB'(gnt), NB'(tbl[k].gnt));
            k++;
         end
      end
      chk({tag, "_shift_count"}, NB'(shift_cnt - s0), NB'(96));
      chk({tag, "_load_count"}, NB'(load_cnt - l0), NB'(1));
      chk({tag, "_dna"}, dna, PAT);
   endtask

   initial begin
      int lc0;
      int s0;
      logic hit;

      //         edge  rd    sh    busy  valid gnt
      tbl[0]  = '{1,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{2,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{3,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{4,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{5,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{193, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{194, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{195, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{196, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{197, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

      // reset state
      repeat (3) adv();
      chk("rst_busy", NB'(busy), '0);
      chk("rst_valid", NB'(valid), '0);
      chk("rst_gnt", NB'(gnt), '0);
      chk("rst_rd", NB'(rd), '0);
      chk("rst_sh", NB'(sh), '0);
      chk("rst_dna", dna, '0);

      // 1: autoload after reset release
      release_reset();
      run_autoload("t1");

      // 2: two reloads mid-read merge into one follow-up read
      lc0 = load_cnt;
      model_pat = P2;
      exp_q.push_back(P2);
      reload = 1'b1;
      adv();
      reload = 1'b0;
      chk("t2_a_rd", NB'(rd), NB'(1));
      chk("t2_a_valid_clr", NB'(valid), '0);
      chk("t2_a_dna_kept", dna, PAT);
      repeat (40) adv();
      model_pat = P3;
      reload = 1'b1;
      adv();
      reload = 1'b0;
      adv();
      reload = 1'b1;
      adv();
      reload = 1'b0;
      exp_q.push_back(P3);
      wait_for(W_VALID, 300, "t2_a_done");
      wait_for(W_READ, 10, "t2_b_load");
      chk("t2_b_valid_low", NB'(valid), '0);
      chk("t2_b_dna_kept", dna, P2);
      repeat (100) adv();
      chk("t2_b_mid_dna", dna, P2);
      chk("t2_b_mid_valid", NB'(valid), '0);
      chk("t2_b_mid_busy", NB'(busy), NB'(1));
      wait_for(W_VALID, 300, "t2_b_done");
      chk("t2_b_dna", dna, P3);
      repeat (250) adv();
      chk("t2_load_count", NB'(load_cnt - lc0), NB'(2));
      chk("t2_idle_busy", NB'(busy), '0);

`ifdef SURF_DNA_BITBANG_EN
      // 3: same-cycle tie goes to the sequencer; grant follows the read
      model_pat = PAT;
      exp_q.push_back(PAT);
      bb_req = 1'b1;
      reload = 1'b1;
      adv();
      reload = 1'b0;
      chk("t3_tie_rd", NB'(rd), NB'(1));
      chk("t3_tie_gnt", NB'(gnt), '0);
      wait_for(W_VALID, 300, "t3_done");
      chk("t3_done_gnt", NB'(gnt), '0);
      adv();
      chk("t3_idle_busy", NB'(busy), '0);
      chk("t3_idle_gnt", NB'(gnt), '0);
      adv();
      chk("t3_gnt", NB'(gnt), NB'(1));
      chk("t3_gnt_sh", NB'(sh), '0);
      bb_shift = 1'b1;
      adv();
      chk("t3_echo_sh", NB'(sh), NB'(1));
      bb_shift = 1'b0;
      bb_read = 1'b1;
      adv();
      chk("t3_echo_sh_off", NB'(sh), '0);
      chk("t3_echo_rd", NB'(rd), NB'(1));
      bb_read = 1'b0;
      adv();
      chk("t3_echo_rd_off", NB'(rd), '0);
      chk("t3_bb_valid", NB'(valid), NB'(1));
      chk("t3_bb_dna", dna, PAT);

      // 4: reload while granted waits for the bit-bang path to release
      lc0 = load_cnt;
      reload = 1'b1;
      adv();
      reload = 1'b0;
      chk("t4_hold_gnt", NB'(gnt), NB'(1));
      chk("t4_hold_rd", NB'(rd), '0);
      chk("t4_hold_busy", NB'(busy), '0);
      repeat (5) adv();
      chk("t4_no_load", NB'(load_cnt - lc0), '0);
      chk("t4_still_gnt", NB'(gnt), NB'(1));
      model_pat = P4;
      exp_q.push_back(P4);
      bb_shift = 1'b1;
      bb_req = 1'b0;
      adv();
      chk("t4_drop_gnt", NB'(gnt), '0);
      chk("t4_drop_sh", NB'(sh), '0);
      chk("t4_drop_rd", NB'(rd), '0);
      adv();
      chk("t4_load_rd", NB'(rd), NB'(1));
      chk("t4_load_sh", NB'(sh), '0);
      chk("t4_load_busy", NB'(busy), NB'(1));
      chk("t4_load_valid", NB'(valid), '0);
      adv();
      chk("t4_settle_sh", NB'(sh), '0);
      bb_shift = 1'b0;
      wait_for(W_VALID, 300, "t4_done");
      chk("t4_dna", dna, P4);
      chk("t4_load_count", NB'(load_cnt - lc0), NB'(1));
      repeat (3) adv();
`else
      // 6: without bit-bang support the bb_* inputs have no effect
      rst_n = 1'b0;
      bb_req = 1'b1;
      bb_read = 1'b1;
      bb_shift = 1'b1;
      repeat (2) adv();
      release_reset();
      run_autoload("t6");
      exp_q.push_back(P2);
      model_pat = P2;
      reload = 1'b1;
      adv();
      reload = 1'b0;
      chk("t6_tie_rd", NB'(rd), NB'(1));
      wait_for(W_VALID, 300, "t6_done");
      repeat (5) adv();
      chk("t6_no_gnt", NB'(gnt), '0);
      chk("t6_no_rd", NB'(rd), '0);
      chk("t6_no_sh", NB'(sh), '0);
      chk("t6_dna", dna, P2);
      bb_req = 1'b0;
      bb_read = 1'b0;
      bb_shift = 1'b0;
`endif

      // 5: reset in the middle of SHIFT, then a clean autoload
      model_pat = P3;
      exp_q.push_back(P3);
      s0 = shift_cnt;
      reload = 1'b1;
      adv();
      reload = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         adv();
         if (shift_cnt - s0 >= 40) begin
            hit = 1'b1;
            break;
         end
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL t5_reach_bit40: got timeout expected 40 shifts");
      end
      rst_n = 1'b0;
      #1;
      chk("t5_rst_busy", NB'(busy), '0);
      chk("t5_rst_valid", NB'(valid), '0);
      chk("t5_rst_gnt", NB'(gnt), '0);
      chk("t5_rst_rd", NB'(rd), '0);
      chk("t5_rst_sh", NB'(sh), '0);
      chk("t5_rst_dna", dna, '0);
      repeat (2) adv();
      release_reset();
      run_autoload("t5");

      chk("sb_empty", NB'(exp_q.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "watchdog");
   end

endmodule
